// File: rtl/electronic_scan_ctrl.sv
// electronic_scan_ctrl
// Per-taxel scan sequencer for the tactile array. For each taxel it drives the
// drive/read mux selects, lets the analog path settle, fires one ADC conversion
// aligned to adc_tick, waits (with timeout) for the result and emits a tagged
// sample. Frames walk the array in row-major order, optionally back-to-back.
module electronic_scan_ctrl #(
    parameter int DRV_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT  = 16,
    parameter int ADC_TQUIET   = 4,
    parameter int SETTLE_CYC   = 8,
    parameter int TIMEOUT_CYC  = 1023,
    parameter int DATA_W       = 12
) (
    input  logic                            clk_ref,
    input  logic                            rst_n,
    input  logic                            adc_tick,
    input  logic                            start,
    input  logic                            continuous,
    output logic [$clog2(DRV_WIRE_CNT)-1:0] drv_sel,
    output logic [$clog2(RD_WIRE_CNT)-1:0]  rd_sel,
    output logic                            adc_conv,
    input  logic                            adc_done,
    input  logic [DATA_W-1:0]               adc_data,
    output logic                            sample_valid,
    output logic [DATA_W-1:0]               sample_data,
    output logic [$clog2(DRV_WIRE_CNT)-1:0] sample_drv,
    output logic [$clog2(RD_WIRE_CNT)-1:0]  sample_rd,
    output logic                            frame_done,
    output logic                            busy,
    output logic                            err_timeout
);

    localparam int DW         = $clog2(DRV_WIRE_CNT);
    localparam int RW         = $clog2(RD_WIRE_CNT);
    localparam int SW         = (SETTLE_CYC > 1)  ? $clog2(SETTLE_CYC)  : 1;
    localparam int TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int QW         = (ADC_TQUIET > 1)  ? $clog2(ADC_TQUIET)  : 1;
    localparam int QUIET_LAST = (ADC_TQUIET > 0)  ? ADC_TQUIET - 1      : 0;

    localparam logic [DW-1:0] DRV_LAST    = DW'(DRV_WIRE_CNT - 1);
    localparam logic [RW-1:0] RD_LAST     = RW'(RD_WIRE_CNT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] WAIT_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [QW-1:0] QUIET_END   = QW'(QUIET_LAST);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ARM    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_QUIET  = 3'd4
    } state_t;

    state_t            r_state;
    logic [SW-1:0]     r_set_cnt;
    logic [TW-1:0]     r_wait_cnt;
    logic [QW-1:0]     r_quiet_cnt;
    logic [DW-1:0]     r_drv_sel;
    logic [RW-1:0]     r_rd_sel;
    logic              r_adc_conv;
    logic              r_sample_valid;
    logic [DATA_W-1:0] r_sample_data;
    logic [DW-1:0]     r_sample_drv;
    logic [RW-1:0]     r_sample_rd;
    logic              r_frame_done;
    logic              r_busy;
    logic              r_err_timeout;

    logic              w_quiet_done;

    // Quiet period ends on the tick that completes the count (or immediately when no quiet time is configured)
    assign w_quiet_done = (ADC_TQUIET == 0) ? 1'b1 : (adc_tick && (r_quiet_cnt == QUIET_END));

    // Scan sequencer: state, counters and all registered outputs
    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_set_cnt      <= '0;
            r_wait_cnt     <= '0;
            r_quiet_cnt    <= '0;
            r_drv_sel      <= '0;
            r_rd_sel       <= '0;
            r_adc_conv     <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
            r_sample_drv   <= '0;
            r_sample_rd    <= '0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            // single-cycle strobes default low
            r_adc_conv     <= 1'b0;
            r_sample_valid <= 1'b0;
            r_frame_done   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // a start landing in the frame_done cycle belongs to the frame just finished
                    if (continuous || (start && !r_frame_done)) begin
                        r_drv_sel <= '0;
                        r_rd_sel  <= '0;
                        r_set_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SETTLE;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end

                ST_SETTLE: begin
                    if (r_set_cnt == SETTLE_LAST) begin
                        r_state   <= ST_ARM;
                    end else begin
                        r_set_cnt <= r_set_cnt + SW'(1);
                    end
                end

                ST_ARM: begin
                    if (adc_tick) begin
                        r_adc_conv <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_state    <= ST_ARM;
                    end
                end

                ST_WAIT: begin
                    // the conversion-trigger cycle itself (count 0) never accepts adc_done
                    if ((r_wait_cnt != '0) && adc_done) begin
                        r_sample_valid <= 1'b1;
                        r_sample_data  <= adc_data;
                        r_sample_drv   <= r_drv_sel;
                        r_sample_rd    <= r_rd_sel;
                        r_quiet_cnt    <= '0;
                        r_state        <= ST_QUIET;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_err_timeout  <= 1'b1;
                        r_drv_sel      <= '0;
                        r_rd_sel       <= '0;
                        r_busy         <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_wait_cnt     <= r_wait_cnt + TW'(1);
                    end
                end

                ST_QUIET: begin
                    if (w_quiet_done) begin
                        r_set_cnt <= '0;
                        if (r_rd_sel == RD_LAST) begin
                            r_rd_sel <= '0;
                            if (r_drv_sel == DRV_LAST) begin
                                r_drv_sel    <= '0;
                                r_frame_done <= 1'b1;
                                if (continuous) begin
                                    r_state <= ST_SETTLE;
                                end else begin
                                    r_busy  <= 1'b0;
                                    r_state <= ST_IDLE;
                                end
                            end else begin
                                r_drv_sel <= r_drv_sel + DW'(1);
                                r_state   <= ST_SETTLE;
                            end
                        end else begin
                            r_rd_sel <= r_rd_sel + RW'(1);
                            r_state  <= ST_SETTLE;
                        end
                    end else if (adc_tick) begin
                        r_quiet_cnt <= r_quiet_cnt + QW'(1);
                    end else begin
                        r_quiet_cnt <= r_quiet_cnt;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign drv_sel      = r_drv_sel;
    assign rd_sel       = r_rd_sel;
    assign adc_conv     = r_adc_conv;
    assign sample_valid = r_sample_valid;
    assign sample_data  = r_sample_data;
    assign sample_drv   = r_sample_drv;
    assign sample_rd    = r_sample_rd;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;
    assign err_timeout  = r_err_timeout;

endmodule
